mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mau_pkg.sv | 30 +++
 rtl/mau_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// FSM state type and the default data memory size used for bounds checks.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int MAU_MEM_BYTES = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } mau_state_e;

    // Number of bytes touched by an access; reserved size counts as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane logic: load extract/extend and store merge.
// Ports: ld_word_i (raw memory word for loads), st_word_i (old word for
// merge), addr_lo_i, size_i, signed_i, wdata_i -> ld_data_o, st_word_o.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [31:0] st_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [4:0]  shamt;
    logic [15:0] ld_sh;
    logic [31:0] lane_mask;
    logic [31:0] st_mask;
    logic [31:0] st_data;

    assign shamt = {addr_lo_i, 3'b000};
    assign ld_sh = 16'(ld_word_i >> shamt);

    always_comb begin
        ld_data_o = ld_word_i;
        lane_mask = 32'hFFFF_FFFF;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = {{24{signed_i & ld_sh[7]}}, ld_sh[7:0]};
                lane_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                ld_data_o = {{16{signed_i & ld_sh[15]}}, ld_sh};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    // Word stores are aligned, so shamt is 0 and the whole word is replaced.
    assign st_mask   = lane_mask << shamt;
    assign st_data   = (wdata_i & lane_mask) << shamt;
    assign st_word_o = (st_word_i & ~st_mask) | st_data;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time, read-modify-write for sub-word
// stores, error response for illegal requests. Ports: req_* handshake in,
// resp_* handshake out, mem_* single-cycle memory port.
// Optional MAU_BOUNDS_CHECK_EN: reject accesses beyond MEM_BYTES.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int MEM_BYTES = MAU_MEM_BYTES
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_i
);

    mau_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic [32:0] req_end;
    logic        misalign;
    logic        oob;
    logic        req_bad;

    assign req_end  = {1'b0, req_addr_i} + 33'(size_bytes(req_size_i));
    assign oob      = req_end > 33'(MEM_BYTES);
    assign misalign = (req_size_i == SZ_RSVD)
                    | ((req_size_i == SZ_WORD) & (req_addr_i[1:0] != 2'b00))
                    | ((req_size_i == SZ_HALF) & req_addr_i[0]);

`ifdef MAU_BOUNDS_CHECK_EN
    assign req_bad = misalign | oob;
`else
    logic unused_oob;
    assign unused_oob = oob;
    assign req_bad    = misalign;
`endif

    mau_lane_align u_align (
        .ld_word_i (mem_data_i),
        .st_word_i (data_q),
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (sgn_q),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        resp_rdata_o = '0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = rst_n_i;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    sgn_d   = req_signed_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    data_d  = '0;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = ST_RESP;
                    else if (req_we_i && req_size_i == SZ_WORD)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                mem_read_o = 1'b1;
                mem_addr_o = {addr_q[31:2], 2'b00};
                // Stores keep the raw word for merging; loads keep the result.
                data_d     = we_q ? mem_data_i : ld_data;
                state_d    = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_write_o = 1'b1;
                mem_addr_o  = {addr_q[31:2], 2'b00};
                mem_data_o  = st_word;
                data_d      = '0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = data_q;
                if (resp_ready_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
